// File: rtl/ysyx_22040386_if_fetch_pkg.sv
// ysyx_22040386_if_fetch_pkg: shared constants and FSM encoding for the fetch stage
package ysyx_22040386_if_fetch_pkg;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_e;
endpackage

// File: rtl/ysyx_22040386_if_buf.sv
// ysyx_22040386_if_buf: one-entry inst/pc holding buffer presenting NOP/0 when empty
module ysyx_22040386_if_buf #(
  parameter logic [31:0] NOP_INST = ysyx_22040386_if_fetch_pkg::DEFAULT_NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        consume_i,
  input  logic        flush_i,
  input  logic [31:0] inst_i,
  input  logic [63:0] pc_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        valid_o
);
  logic        valid_q, valid_d;
  logic [31:0] inst_q;
  logic [63:0] pc_q;
  always_comb valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : consume_i ? 1'b0 : valid_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        inst_q <= inst_i;
        pc_q   <= pc_i;
      end
    end
  end
  always_comb begin
    valid_o = valid_q;
    inst_o  = valid_q ? inst_q : NOP_INST;
    pc_o    = valid_q ? pc_q : 64'd0;
  end
endmodule

// File: rtl/ysyx_22040386_if_fetch.sv
// ysyx_22040386_if_fetch: IF stage issuing one-outstanding imem fetches into a one-entry IF/ID buffer
module ysyx_22040386_if_fetch #(
  parameter logic [63:0] RESET_PC = ysyx_22040386_if_fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = ysyx_22040386_if_fetch_pkg::DEFAULT_NOP_INST
) (
  input  logic        i_if_fetch_clk,
  input  logic        i_if_fetch_rst_n,
  input  logic        i_if_fetch_jump_flag,
  input  logic [63:0] i_if_fetch_jump_pc,
  input  logic        i_if_fetch_load_use_flag,
  output logic        o_if_fetch_imem_req_valid,
  input  logic        i_if_fetch_imem_req_ready,
  output logic [63:0] o_if_fetch_imem_addr,
  input  logic        i_if_fetch_imem_rsp_valid,
  input  logic [31:0] i_if_fetch_imem_rsp_data,
  output logic [31:0] o_if_fetch_inst,
  output logic [63:0] o_if_fetch_pc,
  output logic [4:0]  o_if_fetch_reg_rd_addr1,
  output logic [4:0]  o_if_fetch_reg_rd_addr2,
  output logic        o_if_fetch_inst_valid
);
  import ysyx_22040386_if_fetch_pkg::*;
  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic        buf_valid, consume, fire, load;
  assign consume = buf_valid & ~i_if_fetch_jump_flag & ~i_if_fetch_load_use_flag;
  assign fire    = o_if_fetch_imem_req_valid & i_if_fetch_imem_req_ready;
  always_ff @(posedge i_if_fetch_clk or negedge i_if_fetch_rst_n) begin
    if (!i_if_fetch_rst_n) state_q <= S_REQ;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == S_REQ ? (fire ? S_WAIT : S_REQ)
                               : (i_if_fetch_imem_rsp_valid ? S_REQ : S_WAIT);
  end
  always_comb begin
    o_if_fetch_imem_req_valid = i_if_fetch_rst_n & (state_q == S_REQ) & ~i_if_fetch_jump_flag
                              & (~buf_valid | consume);
    o_if_fetch_imem_addr      = fetch_pc_q;
    load = (state_q == S_WAIT) & i_if_fetch_imem_rsp_valid & ~drop_q & ~i_if_fetch_jump_flag;
  end
  // a jump while a request is in flight poisons that response; a response in the jump cycle clears it
  always_comb begin
    fetch_pc_d = i_if_fetch_jump_flag ? (i_if_fetch_jump_pc & ~64'd3)
               : fire ? fetch_pc_q + 64'd4 : fetch_pc_q;
    req_pc_d   = fire ? fetch_pc_q : req_pc_q;
    drop_d     = state_q == S_WAIT ? (i_if_fetch_imem_rsp_valid ? 1'b0 : (i_if_fetch_jump_flag | drop_q))
                                   : drop_q;
  end
  always_ff @(posedge i_if_fetch_clk or negedge i_if_fetch_rst_n) begin
    if (!i_if_fetch_rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
    end
  end
  ysyx_22040386_if_buf #(.NOP_INST(NOP_INST)) u_buf (
    .clk_i    (i_if_fetch_clk),
    .rst_ni   (i_if_fetch_rst_n),
    .load_i   (load),
    .consume_i(consume),
    .flush_i  (i_if_fetch_jump_flag),
    .inst_i   (i_if_fetch_imem_rsp_data),
    .pc_i     (req_pc_q),
    .inst_o   (o_if_fetch_inst),
    .pc_o     (o_if_fetch_pc),
    .valid_o  (buf_valid)
  );
  assign o_if_fetch_inst_valid   = buf_valid;
  assign o_if_fetch_reg_rd_addr1 = o_if_fetch_inst[19:15];
  assign o_if_fetch_reg_rd_addr2 = o_if_fetch_inst[24:20];
endmodule

// File: tb/tb_ysyx_22040386_if_fetch.sv
// tb_ysyx_22040386_if_fetch: directed bench with imem responder model and instruction scoreboard
module tb_ysyx_22040386_if_fetch;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  logic        clk = 0, rst_n = 0, jump = 0, ld = 0, ready = 0, rsp_valid = 0;
  logic [63:0] jpc = '0;
  logic [31:0] rsp_data = '0;
  logic        req_valid, inst_valid;
  logic [63:0] addr, pc;
  logic [31:0] inst;
  logic [4:0]  rd1, rd2;
  int          checks = 0, errors = 0;
  logic [95:0] exp_q[$];
  logic [63:0] fired[$];
  logic [63:0] model_pc = RST_PC, paddr = '0;
  bit          pending = 0, pdrop = 0, fired_now = 0;
  int          cnt = 0, lat = 1, ncons = 0;

  always #5 clk = ~clk;

  ysyx_22040386_if_fetch dut (
    .i_if_fetch_clk           (clk),
    .i_if_fetch_rst_n         (rst_n),
    .i_if_fetch_jump_flag     (jump),
    .i_if_fetch_jump_pc       (jpc),
    .i_if_fetch_load_use_flag (ld),
    .o_if_fetch_imem_req_valid(req_valid),
    .i_if_fetch_imem_req_ready(ready),
    .o_if_fetch_imem_addr     (addr),
    .i_if_fetch_imem_rsp_valid(rsp_valid),
    .i_if_fetch_imem_rsp_data (rsp_data),
    .o_if_fetch_inst          (inst),
    .o_if_fetch_pc            (pc),
    .o_if_fetch_reg_rd_addr1  (rd1),
    .o_if_fetch_reg_rd_addr2  (rd2),
    .o_if_fetch_inst_valid    (inst_valid)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle: drive the responder, check outputs, update the model, advance to the next negedge
  task automatic tick();
    logic [95:0] e;
    logic [31:0] ei;
    rsp_valid = pending && cnt == 0;
    rsp_data  = rsp_valid ? mem(paddr) : 32'h0;
    #1;
    fired_now = 0;
    if (jump) chk("req_in_jump", req_valid, 0);
    if (!inst_valid) begin
      chk("empty_inst", inst, NOP);
      chk("empty_pc", pc, 0);
    end
    if (inst_valid && (jump || !ld)) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ei = e[95:64];
        if (!jump) begin
          chk("inst", inst, ei);
          chk("pc", pc, e[63:0]);
          chk("rd1", rd1, ei[19:15]);
          chk("rd2", rd2, ei[24:20]);
          ncons++;
        end
      end
    end
    if (rsp_valid) begin
      if (!jump && !pdrop) exp_q.push_back({mem(paddr), paddr});
      pending = 0;
      pdrop = 0;
    end else if (pending) begin
      if (jump) pdrop = 1;
      if (cnt > 0) cnt--;
    end
    if (req_valid && ready) begin
      chk("addr", addr, model_pc);
      chk("one_outstanding", pending, 0);
      fired.push_back(addr);
      paddr = addr;
      pending = 1;
      cnt = lat - 1;
      fired_now = 1;
      model_pc = model_pc + 64'd4;
    end
    if (jump) model_pc = jpc & ~64'd3;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_fire(input string tag, input int max);
    int n;
    n = 0;
    fired_now = 0;
    while (!fired_now && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_fire"}, fired_now, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, req_valid, 0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_rd1"}, rd1, 0);
    chk({tag, "_rd2"}, rd2, 0);
    chk({tag, "_valid"}, inst_valid, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1 chk_reset_outputs(tag);
    pending = 0;
    pdrop = 0;
    rsp_valid = 0;
    exp_q.delete();
    model_pc = RST_PC;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    ready = 1;
    #12 chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    repeat (6) tick();
    chk("addr0", fired[0], 64'h8000_0000);
    chk("addr1", fired[1], 64'h8000_0004);
    chk("addr2", fired[2], 64'h8000_0008);
    chk("throughput", ncons, 2);
    ld = 1;
    repeat (3) begin
      #1;
      chk("ld_req", req_valid, 0);
      chk("ld_pc", pc, 64'h8000_0008);
      chk("ld_inst", inst, mem(64'h8000_0008));
      chk("ld_valid", inst_valid, 1);
      tick();
    end
    ld = 0;
    lat = 3;
    tick();
    chk("after_ld_addr", fired[fired.size()-1], 64'h8000_000C);
    jump = 1;
    jpc = 64'h8000_1002;
    tick();
    jump = 0;
    #1 chk("drop_wait_req", req_valid, 0);
    lat = 1;
    run_until_fire("jmp_wait", 8);
    chk("jmp_wait_addr", fired[fired.size()-1], 64'h8000_1000);
    chk("drop_sb", exp_q.size(), 0);
    jump = 1;
    jpc = 64'h8000_2000;
    tick();
    jump = 0;
    #1 chk("jrsp_valid", inst_valid, 0);
    run_until_fire("jrsp", 4);
    chk("jrsp_addr", fired[fired.size()-1], 64'h8000_2000);
    tick();
    ld = 1;
    jump = 1;
    jpc = 64'h8000_3004;
    tick();
    jump = 0;
    #1 chk("jld_valid", inst_valid, 0);
    run_until_fire("jld", 4);
    ld = 0;
    chk("jld_addr", fired[fired.size()-1], 64'h8000_3004);
    tick();
    jump = 1;
    jpc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    jump = 0;
    run_until_fire("wrap_a", 4);
    chk("wrap_a_addr", fired[fired.size()-1], 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    run_until_fire("wrap_b", 4);
    chk("wrap_b_addr", fired[fired.size()-1], 64'h0);
    async_reset("rst_wait");
    run_until_fire("post_rst", 4);
    chk("post_rst_addr", fired[fired.size()-1], RST_PC);
    tick();
    ld = 1;
    tick();
    chk("pre_rst2_valid", inst_valid, 1);
    async_reset("rst_full");
    ld = 0;
    run_until_fire("post_rst2", 4);
    chk("post_rst2_addr", fired[fired.size()-1], RST_PC);
    tick();
    tick();
    chk("final_sb", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
